// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment display path.
// NIBBLE_W is also used by the downstream ssd decoder.
package ssd_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  function automatic logic [MAX_DIGITS-1:0] onehot(
    input logic [2:0] idx
  );
    logic [MAX_DIGITS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// Slot timer for the display scan: counts DIV cycles per digit slot
// and flags the leading guard window of each slot.
module ssd_prescaler #(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic in_guard
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick     = (cnt == CW'(DIV - 1));
  assign in_guard = (int'(cnt) < GUARD);

endmodule

// File: rtl/ssd_scan_mux.sv
// Seven-segment scan controller: walks the digits one slot at a time and
// swaps in newly loaded values only at frame boundaries.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 16,
  parameter int LZS    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NIBBLE_W*DIGITS-1:0]   data_in,
  input  logic                         load,
  output logic [NIBBLE_W-1:0]          digit,
  output logic [DIGITS-1:0]            an,
  output logic                         frame_done
);

  localparam int DW = NIBBLE_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic          tick;
  logic          in_guard;
  logic [IW-1:0] idx;
  logic [DW-1:0] pend;
  logic [DW-1:0] disp;
  logic          pend_v;
  logic          last;
  logic          fin;

  ssd_prescaler #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_pre (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .in_guard (in_guard)
  );

  assign last       = (idx == IW'(DIGITS - 1));
  assign fin        = tick && last;
  assign frame_done = fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      disp   <= '0;
    end else begin
      if (tick) begin
        idx <= last ? '0 : idx + IW'(1);
      end
      // a load on the boundary cycle bypasses pend entirely
      if (fin) begin
        pend_v <= 1'b0;
        if (load) begin
          disp <= data_in;
        end else if (pend_v) begin
          disp <= pend;
        end
      end else if (load) begin
        pend   <= data_in;
        pend_v <= 1'b1;
      end
    end
  end

  logic                  hi_zero;
  logic                  sup;
  logic [MAX_DIGITS-1:0] oh;

  always_comb begin
    digit   = '0;
    hi_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(idx) == k) begin
        digit = disp[k*NIBBLE_W +: NIBBLE_W];
      end
      if (k >= int'(idx) && disp[k*NIBBLE_W +: NIBBLE_W] != '0) begin
        hi_zero = 1'b0;
      end
    end
    sup = (LZS != 0) && (idx != '0) && hi_zero;
    oh  = onehot(3'(idx));
    an  = (in_guard || sup) ? '0 : oh[DIGITS-1:0];
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: two instances (LZS off/on) share clk, rst and
// load; per-frame expectations are queued and checked cycle by cycle.
module tb_ssd_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dig0, dig1, an0, an1;
  logic        fd0, fd1;

  always #5 clk = ~clk;

  ssd_scan_mux #(.DIGITS(4), .DIV(4), .GUARD(1), .LZS(0)) u0 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .digit(dig0), .an(an0), .frame_done(fd0)
  );

  ssd_scan_mux #(.DIGITS(4), .DIV(4), .GUARD(1), .LZS(1)) u1 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .digit(dig1), .an(an1), .frame_done(fd1)
  );

  typedef struct {
    logic [3:0] dig;
    logic [3:0] an0;
    logic [3:0] an1;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0] val;
    logic [15:0] an1;
    bit          at_end;
  } vec_t;

  exp_t q[$];
  vec_t vt[7];
  int   total = 0;
  int   bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic wait_end(input int lim);
    int n;
    n = 0;
    while (fd0 !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk("frame_done_reached", {15'd0, fd0}, 16'd1);
  endtask

  task automatic expect_frame(input logic [15:0] val,
                              input logic [15:0] a1);
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        e.dig = val[s*4 +: 4];
        e.an0 = (c == 0) ? 4'd0 : 4'(1 << s);
        e.an1 = (c == 0) ? 4'd0 : a1[s*4 +: 4];
        e.fd  = (s == 3 && c == 3);
        q.push_back(e);
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("digit_lzs0", {12'd0, dig0}, {12'd0, e.dig});
      chk("digit_lzs1", {12'd0, dig1}, {12'd0, e.dig});
      chk("an_lzs0", {12'd0, an0}, {12'd0, e.an0});
      chk("an_lzs1", {12'd0, an1}, {12'd0, e.an1});
      chk("frame_done", {15'd0, fd0}, {15'd0, e.fd});
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'h0050, 16'h0021, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0};
    vt[2] = '{16'hABCD, 16'h8421, 1'b1};
    vt[3] = '{16'h0100, 16'h0421, 1'b0};
    vt[4] = '{16'h8000, 16'h8421, 1'b1};
    vt[5] = '{16'h000F, 16'h0001, 1'b0};
    vt[6] = '{16'h0A00, 16'h0421, 1'b0};

    // reset held for three edges
    rst = 1'b1;
    repeat (3) step();
    chk("rst_an0", {12'd0, an0}, 16'd0);
    chk("rst_an1", {12'd0, an1}, 16'd0);
    chk("rst_digit", {12'd0, dig0}, 16'd0);
    chk("rst_fd", {15'd0, fd0}, 16'd0);
    rst = 1'b0;
    chk("c0_an", {12'd0, an0}, 16'd0);
    for (int c = 1; c < 16; c++) begin
      step();
      if (c <= 3) chk("c1_3_an", {12'd0, an0}, 16'd1);
      if (c < 15) chk("fd_early", {15'd0, fd0}, 16'd0);
    end
    chk("fd_c15", {15'd0, fd0}, 16'd1);

    // load mid-frame; old (zero) display holds until the boundary
    repeat (6) step();
    data_in = 16'h1234;
    load    = 1'b1;
    step();
    load    = 1'b0;
    for (int n = 0; n < 20 && fd0 !== 1'b1; n++) begin
      chk("hold_digit", {12'd0, dig0}, 16'd0);
      step();
    end
    chk("fd_commit", {15'd0, fd0}, 16'd1);
    step();
    expect_frame(16'h1234, 16'h8421);

    foreach (vt[i]) begin
      data_in = vt[i].val;
      if (vt[i].at_end) begin
        wait_end(20);
        load = 1'b1;
        step();
        load = 1'b0;
      end else begin
        repeat (2) step();
        load = 1'b1;
        step();
        load = 1'b0;
        wait_end(20);
        step();
      end
      expect_frame(vt[i].val, vt[i].an1);
    end

    // two loads in one frame: the later one is shown
    step();
    data_in = 16'h1111;
    load    = 1'b1;
    step();
    load    = 1'b0;
    repeat (2) step();
    data_in = 16'h2222;
    load    = 1'b1;
    step();
    load    = 1'b0;
    wait_end(20);
    step();
    expect_frame(16'h2222, 16'h8421);

    // reset in slot 2, then reset together with a load
    data_in = 16'h1234;
    repeat (2) step();
    load = 1'b1;
    step();
    load = 1'b0;
    wait_end(20);
    step();
    expect_frame(16'h1234, 16'h8421);
    repeat (9) step();
    chk("pre_rst_an", {12'd0, an0}, 16'h0004);
    chk("pre_rst_digit", {12'd0, dig0}, 16'h0002);
    rst = 1'b1;
    step();
    chk("midrst_an", {12'd0, an0}, 16'd0);
    chk("midrst_digit", {12'd0, dig0}, 16'd0);
    chk("midrst_fd", {15'd0, fd0}, 16'd0);
    data_in = 16'hFFFF;
    load    = 1'b1;
    step();
    load    = 1'b0;
    rst     = 1'b0;
    expect_frame(16'h0000, 16'h0001);
    expect_frame(16'h0000, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
